// File: rtl/sbc32_serial.sv
// rtl/sbc32_serial.sv - digit-serial 32-bit subtract-with-borrow, LS slice first
// Optional zero/ovf flag outputs are enabled by defining SBC_FLAGS_EN.
module sbc32_serial #(
    parameter int DIGIT_W = 8    // slice width; one of 1, 2, 4, 8, 16, 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] D
`ifdef SBC_FLAGS_EN
    ,
    output logic        zero,
    output logic        ovf
`endif
);

    localparam int NSLICE = 32 / DIGIT_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [31:0]      a_sh;
    logic [31:0]      b_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [DIGIT_W:0] diff;
    logic [31:0]      a_next;

    always_comb begin
        diff = {1'b0, a_sh[DIGIT_W-1:0]} - {1'b0, b_sh[DIGIT_W-1:0]}
             - {{DIGIT_W{1'b0}}, borrow};
    end

    // Result slices fill the top of a_sh as minuend slices drain out the bottom,
    // so after NSLICE steps a_sh holds the whole difference.
    generate
        if (DIGIT_W == 32) begin : g_single
            assign a_next = diff[31:0];
        end else begin : g_multi
            assign a_next = {diff[DIGIT_W-1:0], a_sh[31:DIGIT_W]};
        end
    endgenerate

`ifdef SBC_FLAGS_EN
    logic a_msb;
    logic b_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
`ifdef SBC_FLAGS_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow   <= Bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
`ifdef SBC_FLAGS_EN
                        a_msb    <= A[31];
                        b_msb    <= B[31];
`endif
                    end
                end
                CALC: begin
                    a_sh   <= a_next;
                    b_sh   <= b_sh >> DIGIT_W;
                    borrow <= diff[DIGIT_W];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        D         <= {diff[DIGIT_W], a_next};
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SBC_FLAGS_EN
                        zero      <= (a_next == 32'd0);
                        ovf       <= (a_msb ^ b_msb) & (a_msb ^ a_next[31]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbc32_serial.sv
// tb/tb_sbc32_serial.sv - self-checking bench for sbc32_serial
module tb_sbc32_serial;

    localparam int DW = 8;
    localparam int NS = 32 / DW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] D;
`ifdef SBC_FLAGS_EN
    logic        zero;
    logic        ovf;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sbc32_serial #(.DIGIT_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
`ifdef SBC_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [32:0] d;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, reduced modulo 2^33.
    function automatic logic [32:0] ref_d(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint v;
        v = longint'(a) - longint'(b) - longint'(bin);
        return v[32:0];
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic bin);
        longint s;
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input logic [32:0] exp_d, input logic ez, input logic eo,
                         input int hold, input string tag);
        int n;
        int lat;
        n = 0;
        lat = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk({tag, " in_ready_calc"}, 64'(in_ready), 64'd0);
        while (!out_valid && lat < 100) begin
            A = $urandom; B = $urandom; Bin = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(NS));
        chk({tag, " D"}, 64'(D), 64'(exp_d));
`ifdef SBC_FLAGS_EN
        chk({tag, " zero"}, 64'(zero), 64'(ez));
        chk({tag, " ovf"}, 64'(ovf), 64'(eo));
`else
        if (ez === 1'bx || eo === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            A = $urandom; B = $urandom; in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold_D"}, 64'(D), 64'(exp_d));
            chk({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " post_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " post_D"}, 64'(D), 64'(exp_d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic        rbin;
        logic [32:0] rd;

        vt[0] = '{32'd5,        32'd3,        1'b0, 33'h0_00000002, 1'b0, 1'b0};
        vt[1] = '{32'd0,        32'd1,        1'b0, 33'h1_FFFFFFFF, 1'b0, 1'b0};
        vt[2] = '{32'h10000000, 32'd1,        1'b0, 33'h0_0FFFFFFF, 1'b0, 1'b0};
        vt[3] = '{32'h00000100, 32'd1,        1'b1, 33'h0_000000FE, 1'b0, 1'b0};
        vt[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 33'h1_FFFFFFFF, 1'b0, 1'b0};
        vt[5] = '{32'd0,        32'hFFFFFFFF, 1'b1, 33'h1_00000000, 1'b1, 1'b0};
        vt[6] = '{32'h80000000, 32'd1,        1'b0, 33'h0_7FFFFFFF, 1'b0, 1'b1};
        vt[7] = '{32'h1234,     32'h1234,     1'b0, 33'h0_00000000, 1'b1, 1'b0};
        vt[8] = '{32'd7,        32'd9,        1'b0, 33'h1_FFFFFFFE, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset D", 64'(D), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            do_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].z, vt[i].o, i % 3, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : 32'($urandom);
            rbin = 1'($urandom);
            rd = ref_d(ra, rb, rbin);
            do_op(ra, rb, rbin, rd, rd[31:0] == 32'd0, ref_ovf(ra, rb, rbin),
                  $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Backpressure in DONE with new operands already on the input.
        A = 32'h50; B = 32'h20; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 32'h99; B = 32'h11; Bin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp latency", 64'(lat), 64'(NS));
        chk("bp D", 64'(D), 64'h30);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp hold_valid", 64'(out_valid), 64'd1);
            chk("bp hold_D", 64'(D), 64'h30);
            chk("bp hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release_valid", 64'(out_valid), 64'd0);
        chk("bp release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp second_accept", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp second latency", 64'(lat), 64'(NS));
        chk("bp second D", 64'(D), 64'h87);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the second CALC cycle.
        A = 32'd1; B = 32'd2; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst pre_D_nonzero", 64'(D != 33'd0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 64'(out_valid), 64'd0);
        chk("rst async in_ready", 64'(in_ready), 64'd1);
        chk("rst async D", 64'(D), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NS + 2; i++) begin
            @(posedge clk); #1;
            chk("rst no_partial", 64'(out_valid), 64'd0);
        end
        do_op(32'd7, 32'd9, 1'b0, 33'h1_FFFFFFFE, 1'b0, 1'b0, 1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
